// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit bridging the execute stage to a request/response data bus
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [2:0]            mem_op,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic                  bus_wen,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [STRB_WIDTH-1:0] bus_wstrb,
    input  logic                  bus_resp_valid,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  access_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  store_q, store_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

    logic                  req_present;
    logic                  legal;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [STRB_WIDTH-1:0] lane_wstrb;

    // Decode the incoming request and decide whether it may be issued to the bus
    always_comb begin
        req_present = ex_valid & (mem_ren | mem_wen);
        legal       = 1'b1;
        if (mem_op == 3'b011 || mem_op[2:1] == 2'b11)
            legal = 1'b0;
        if (mem_op[1:0] == 2'b01 && alu_out[0])
            legal = 1'b0;
        if (mem_op[1:0] == 2'b10 && alu_out[1:0] != 2'b00)
            legal = 1'b0;
        if (mem_ren && mem_wen)
            legal = 1'b0;
        accept = (state_q == IDLE) & req_present & legal;
    end

    // Replicate store data into the addressed byte lanes and build the strobes
    always_comb begin
        lane_wdata = data_q;
        lane_wstrb = '1;
        case (op_q[1:0])
            2'b00: begin
                lane_wdata = {STRB_WIDTH{data_q[7:0]}};
                lane_wstrb = STRB_WIDTH'(1) << addr_q[1:0];
            end
            2'b01: begin
                lane_wdata = {(STRB_WIDTH / 2){data_q[15:0]}};
                lane_wstrb = STRB_WIDTH'(3) << addr_q[1:0];
            end
            default: begin
                lane_wdata = data_q;
                lane_wstrb = '1;
            end
        endcase
    end

    // Align the returned word to the accessed byte and extend to full width
    always_comb begin
        rdata_shifted = bus_rdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            3'b000:  load_ext = {{(DATA_WIDTH - 8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH - 16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH - 8){1'b0}}, rdata_shifted[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH - 16){1'b0}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // Next-state logic: accept, issue, wait for response, then a single done cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        data_d      = data_q;
        store_d     = store_q;
        err_d       = 1'b0;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = alu_out;
                    op_d    = mem_op;
                    data_d  = rs2;
                    store_d = mem_wen;
                    state_d = REQ;
                end else if (req_present) begin
                    err_d = 1'b1;
                end
            end
            REQ: begin
                if (bus_req_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus_resp_valid) begin
                    state_d = DONE;
                    if (!store_q)
                        load_data_d = load_ext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drive bus and pipeline outputs; write qualifiers only while a request is valid
    always_comb begin
        bus_req_valid = (state_q == REQ);
        bus_addr      = {addr_q[DATA_WIDTH-1:2], 2'b00};
        bus_wdata     = lane_wdata;
        bus_wen       = (state_q == REQ) & store_q;
        bus_wstrb     = ((state_q == REQ) && store_q) ? lane_wstrb : '0;
        stall         = accept | (state_q == REQ) | (state_q == WAIT);
        done          = (state_q == DONE);
        load_data     = load_data_q;
        access_err    = err_q;
    end

    // State and captured-access registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            data_q      <= '0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            data_q      <= data_d;
            store_q     <= store_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  mem_op;
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        access_err;

    int checks;
    int errors;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .mem_ren        (mem_ren),
        .mem_wen        (mem_wen),
        .mem_op         (mem_op),
        .alu_out        (alu_out),
        .rs2            (rs2),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_wen        (bus_wen),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata),
        .stall          (stall),
        .done           (done),
        .load_data      (load_data),
        .access_err     (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, one time unit past the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic ren, input logic wen, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] data);
        ex_valid = 1'b1;
        mem_ren  = ren;
        mem_wen  = wen;
        mem_op   = op;
        alu_out  = addr;
        rs2      = data;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ex_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_op = 3'b000;
        alu_out = '0; rs2 = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0;

        // Reset values
        tick(); tick();
        chk("rst_req_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_wen", 32'(bus_wen), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(access_err), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_load", load_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Signed byte load, immediate ready and response
        present(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
        bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_rdata = 32'h8011_2233;
        #1;
        chk("lb_c0_stall", 32'(stall), 32'd1);
        chk("lb_c0_reqv", 32'(bus_req_valid), 32'd0);
        tick(); idle_in(); #1;
        chk("lb_c1_reqv", 32'(bus_req_valid), 32'd1);
        chk("lb_c1_addr", bus_addr, 32'h0000_1000);
        chk("lb_c1_wen", 32'(bus_wen), 32'd0);
        chk("lb_c1_wstrb", 32'(bus_wstrb), 32'h0);
        chk("lb_c1_stall", 32'(stall), 32'd1);
        tick();
        chk("lb_c2_reqv", 32'(bus_req_valid), 32'd0);
        chk("lb_c2_stall", 32'(stall), 32'd1);
        chk("lb_c2_done", 32'(done), 32'd0);
        tick();
        chk("lb_c3_done", 32'(done), 32'd1);
        chk("lb_c3_stall", 32'(stall), 32'd0);
        chk("lb_c3_load", load_data, 32'hFFFF_FF80);
        tick();
        chk("lb_c4_done", 32'(done), 32'd0);

        // Half store to upper lanes; load_data must be retained
        present(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hABCD_1234);
        #1;
        tick(); idle_in(); #1;
        chk("sh_reqv", 32'(bus_req_valid), 32'd1);
        chk("sh_wdata", bus_wdata, 32'h1234_1234);
        chk("sh_wstrb", 32'(bus_wstrb), 32'hC);
        chk("sh_addr", bus_addr, 32'h0000_2000);
        chk("sh_wen", 32'(bus_wen), 32'd1);
        tick();
        chk("sh_wait_wstrb", 32'(bus_wstrb), 32'h0);
        chk("sh_wait_wen", 32'(bus_wen), 32'd0);
        tick();
        chk("sh_done", 32'(done), 32'd1);
        chk("sh_load_kept", load_data, 32'hFFFF_FF80);
        tick();

        // Misaligned word load
        present(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0);
        #1;
        chk("mis_c0_stall", 32'(stall), 32'd0);
        chk("mis_c0_err", 32'(access_err), 32'd0);
        tick(); idle_in(); #1;
        chk("mis_c1_err", 32'(access_err), 32'd1);
        chk("mis_c1_reqv", 32'(bus_req_valid), 32'd0);
        chk("mis_c1_stall", 32'(stall), 32'd0);
        tick();
        chk("mis_c2_err", 32'(access_err), 32'd0);
        chk("mis_c2_reqv", 32'(bus_req_valid), 32'd0);

        // Reserved size code and simultaneous read/write
        present(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0);
        #1;
        chk("op011_stall", 32'(stall), 32'd0);
        tick(); idle_in(); #1;
        chk("op011_err", 32'(access_err), 32'd1);
        present(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0);
        #1;
        tick(); idle_in(); #1;
        chk("rw_err", 32'(access_err), 32'd1);
        chk("rw_reqv", 32'(bus_req_valid), 32'd0);
        tick();

        // Byte store with ready held low; stray responses in REQ are ignored
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
        present(1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5);
        #1;
        tick(); idle_in(); #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_reqv", 32'(bus_req_valid), 32'd1);
            chk("bp_addr", bus_addr, 32'h0000_5000);
            chk("bp_wdata", bus_wdata, 32'hA5A5_A5A5);
            chk("bp_wstrb", 32'(bus_wstrb), 32'h2);
            chk("bp_stall", 32'(stall), 32'd1);
            tick();
        end
        bus_req_ready = 1'b1;
        #1;
        chk("bp_ready_reqv", 32'(bus_req_valid), 32'd1);
        tick();
        chk("bp_wait_done", 32'(done), 32'd0);
        chk("bp_wait_stall", 32'(stall), 32'd1);
        tick();
        chk("bp_done", 32'(done), 32'd1);
        // A new access offered during DONE is dropped
        present(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        #1;
        chk("bp_done_stall", 32'(stall), 32'd0);
        tick(); idle_in(); #1;
        chk("done_ignore_reqv", 32'(bus_req_valid), 32'd0);
        chk("done_ignore_stall", 32'(stall), 32'd0);
        tick();

        // Reset while waiting for a response
        bus_resp_valid = 1'b0; bus_req_ready = 1'b1;
        present(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
        #1;
        tick(); idle_in(); #1;
        tick();
        chk("rw_wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_reqv", 32'(bus_req_valid), 32'd0);
        chk("arst_load", load_data, 32'h0);
        tick();
        rst_n = 1'b1; bus_resp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_stall", 32'(stall), 32'd0);
            chk("post_rst_load", load_data, 32'h0);
        end

        // Unsigned half load after reset behaves normally
        bus_rdata = 32'h9ABC_0000;
        present(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0);
        #1;
        chk("lhu_c0_stall", 32'(stall), 32'd1);
        tick(); idle_in(); #1;
        chk("lhu_addr", bus_addr, 32'h0000_4000);
        tick(); tick();
        chk("lhu_done", 32'(done), 32'd1);
        chk("lhu_load", load_data, 32'h0000_9ABC);
        tick();

        // Signed half load of the same word
        present(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'h0);
        #1;
        tick(); idle_in(); #1;
        tick(); tick();
        chk("lh_done", 32'(done), 32'd1);
        chk("lh_load", load_data, 32'hFFFF_9ABC);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of address, store data and load data paths.
REQ-002 Parameter STRB_WIDTH, DATA_WIDTH/8, number of byte-write strobes.
REQ-003 Ports SHALL be, in order:
- clk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_valid  in  1  an instruction is present in the execute-to-memory register this cycle.
- mem_ren  in  1  load request.
- mem_wen  in  1  store request.
- mem_op  in  3  funct3 size code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- alu_out  in  DATA_WIDTH  effective byte address.
- rs2  in  DATA_WIDTH  store data, already forwarded.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_addr  out  DATA_WIDTH  word-aligned address, low 2 bits 0.
- bus_wen  out  1  1 = write.
- bus_wdata  out  DATA_WIDTH  lane-shifted store data.
- bus_wstrb  out  STRB_WIDTH  byte-write enables.
- bus_resp_valid  in  1  read data or write acknowledge.
- bus_rdata  in  DATA_WIDTH  raw word read.
- stall  out  1  freeze the upstream pipeline.
- done  out  1  one-cycle pulse; access complete.
- load_data  out  DATA_WIDTH  aligned, extended load result.
- access_err  out  1  one-cycle pulse; misaligned or illegal access.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-005 In IDLE, the block SHALL accept an access when ex_valid & (mem_ren | mem_wen) is true and the access is legal.
- On accept it SHALL register address, mem_op, rs2 and direction, then move to REQ.
- stall SHALL be 1 combinationally in the accept cycle.
REQ-006 Legality: an access SHALL be illegal if any of the following holds:
- half access with addr[0]=1;
- word access with addr[1:0]≠00;
- mem_op is 011, 110 or 111;
- mem_ren and mem_wen are both 1.
REQ-007 Illegal access: no bus request; access_err SHALL pulse in the following cycle; FSM SHALL stay in IDLE; stall SHALL be 0.
REQ-008 REQ: bus_req_valid=1. bus_addr, bus_wen, bus_wdata and bus_wstrb SHALL be driven from the registered values and held stable until bus_req_ready=1. The transition to WAIT SHALL occur on the ready edge.
REQ-009 WAIT: bus_req_valid=0. On bus_resp_valid=1 the FSM SHALL go to DONE; loads SHALL capture the extended data into load_data on that edge.
REQ-010 DONE: done=1 and stall=0 for exactly one cycle, then IDLE. A new access presented in DONE SHALL be ignored; the pipeline advances in this cycle.
REQ-011 stall SHALL be 1 in REQ and WAIT, and 0 in DONE and in non-accepting IDLE cycles.
REQ-012 Store lanes:
- byte: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0];
- half: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0];
- word: wdata = rs2, wstrb = 1111.
REQ-013 Load extraction SHALL shift bus_rdata right by 8*addr[1:0]. Codes 000/001 SHALL sign-extend from bit 7/15; codes 100/101 SHALL zero-extend.
REQ-014 For stores, load_data SHALL retain its previous value; bus_rdata SHALL be ignored.
REQ-015 If bus_resp_valid arrives in IDLE, REQ or DONE, it SHALL be ignored.
REQ-016 Minimum latency with ready and response immediate: accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, done at cycle 3.
REQ-017 bus_wstrb SHALL be 0000 and bus_wen SHALL be 0 whenever bus_req_valid=0.

Reset
REQ-018 On rst_n=0 (asynchronous), the following SHALL hold:
- FSM in IDLE;
- bus_req_valid, bus_wen, stall, done and access_err are 0;
- bus_addr, bus_wdata, load_data are 0; bus_wstrb is 0000.
REQ-019 Reset mid-transaction (REQ or WAIT) SHALL abandon the access; any later bus_resp_valid SHALL be ignored until a new accept.

Verification
REQ-020 Load of byte 0x80 at addr 0x1003, mem_op=000, bus_rdata=0x80112233, ready and resp immediate -> done at cycle 3, load_data=0xFFFFFF80; stall high for cycles 0-2.
REQ-021 Store half rs2=0xABCD1234 at addr 0x2002, mem_op=001 -> bus_wdata=0x12341234, bus_wstrb=1100, bus_addr=0x2000, bus_wen=1.
REQ-022 Word load at addr 0x3001 -> access_err pulse at cycle 1, no bus_req_valid, stall=0 throughout.
REQ-023 bus_req_ready low for 4 cycles -> bus_addr/bus_wdata/bus_wstrb stable, stall=1 throughout; done exactly 2 cycles after ready.
REQ-024 rst_n low while in WAIT, then a stray bus_resp_valid -> outputs at reset values, no done pulse, next access behaves normally.
REQ-025 LHU at addr 0x4002 with bus_rdata=0x9ABC0000 -> load_data=0x00009ABC.
